// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank driven by decoded SPI transactions, with a ready/valid read response port.
//   Inputs : clk, rst_n (sync, active-low), txn_valid/txn_rw/txn_addr/txn_data (deserializer), rd_ready
//   Outputs: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle (addr 0..4),
//            rd_data/rd_valid (read response), err_count (saturating), busy (FSM not IDLE)
//   Optional: define REG_LOCK_EN to add a write-lock register at MAX_ADDR+1.
module spi_reg_bank #(
    parameter int MAX_ADDR  = 4,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 txn_valid,
    input  logic                 txn_rw,
    input  logic [6:0]           txn_addr,
    input  logic [7:0]           txn_data,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                 state_q, state_d;
    logic                   valid_q, rw_q, rw_d, rd_valid_q, rd_valid_d;
    logic [6:0]             addr_q, addr_d;
    logic [7:0]             data_q, data_d, rd_data_q, rd_data_d, reg_rd;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [7:0]             regs_q [MAX_ADDR+1];
    logic [7:0]             regs_d [MAX_ADDR+1];
    logic                   start, addr_ok, lock, lock_hit, wr_ok, err_inc;
    // valid_q resets high so a level held through reset is not seen as a rising edge
    assign start   = txn_valid && !valid_q;
    assign addr_ok = addr_q <= 7'(MAX_ADDR);
`ifdef REG_LOCK_EN
    logic lock_q, lock_d;
    assign lock     = lock_q;
    assign lock_hit = addr_q == 7'(MAX_ADDR + 1);
    assign lock_d   = (state_q == EXEC && rw_q && lock_hit) ? data_q[0] : lock_q;
    always_ff @(posedge clk) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign lock     = 1'b0;
    assign lock_hit = 1'b0;
`endif
    assign wr_ok = addr_ok && !lock;
    // a start outside IDLE is an overrun; all error sources of one cycle merge into a single increment
    assign err_inc = (start && state_q != IDLE) ||
                     (state_q == EXEC && !lock_hit && (rw_q ? !wr_ok : !addr_ok));
    assign err_d   = (err_inc && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
    always_comb begin
        reg_rd = lock_hit ? {7'b0, lock} : 8'h00;
        for (int i = 0; i <= MAX_ADDR; i++)
            if (addr_q == 7'(i)) reg_rd = regs_q[i];
    end
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        regs_d     = regs_q;
        case (state_q)
            IDLE: if (start) begin
                rw_d    = txn_rw;
                addr_d  = txn_addr;
                data_d  = txn_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = rw_q ? IDLE : RESP;
                if (!rw_q) begin
                    rd_data_d  = reg_rd;
                    rd_valid_d = 1'b1;
                end
                for (int i = 0; i <= MAX_ADDR; i++)
                    if (rw_q && wr_ok && addr_q == 7'(i)) regs_d[i] = data_q;
            end
            RESP: if (rd_ready) begin
                rd_valid_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b1;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            valid_q    <= txn_valid;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            regs_q     <= regs_d;
        end
    end
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign err_count       = err_q;
    assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed scoreboard bench for spi_reg_bank.
module tb_spi_reg_bank;
    logic       clk = 1'b0;
    logic       rst_n, txn_valid, txn_rw, rd_ready;
    logic [6:0] txn_addr;
    logic [7:0] txn_data;
    logic [7:0] r0, r1, r2, r3, r4, rd_data;
    logic       rd_valid, busy;
    logic [3:0] err_count;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .txn_valid(txn_valid), .txn_rw(txn_rw),
        .txn_addr(txn_addr), .txn_data(txn_data),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask

    // inputs only change at posedge+1, so a handshake seen at negedge is the one the next edge accepts
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got %0h expected none", rd_data);
            end else chk("rsp_data", rd_data, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle valid pulse; returns just after the EXEC edge
    task automatic txn(input logic rw, input logic [6:0] a, input logic [7:0] d);
        step();
        txn_rw = rw; txn_addr = a; txn_data = d; txn_valid = 1'b1;
        step();
        txn_valid = 1'b0;
        chk("busy_exec", busy, 1'b1);
        step();
    endtask

    task automatic chk_regs(input string n, input logic [39:0] exp);
        chk({n, "_r0"}, r0, exp[7:0]);
        chk({n, "_r1"}, r1, exp[15:8]);
        chk({n, "_r2"}, r2, exp[23:16]);
        chk({n, "_r3"}, r3, exp[31:24]);
        chk({n, "_r4"}, r4, exp[39:32]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; txn_valid = 1'b0; txn_rw = 1'b0; txn_addr = '0; txn_data = '0; rd_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_regs("reset", 40'h0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_err", err_count, 4'h0);
        chk("reset_busy", busy, 1'b0);
        // write is not visible at the capture edge, only one edge later
        step();
        txn_rw = 1'b1; txn_addr = 7'h02; txn_data = 8'hA5; txn_valid = 1'b1;
        step();
        txn_valid = 1'b0;
        chk("t1_before_exec", r2, 8'h00);
        step();
        chk_regs("t1", 40'h00_00_A5_00_00);
        chk("t1_err", err_count, 4'h0);
        chk("t1_busy", busy, 1'b0);
        txn(1'b1, 7'h04, 8'h80);
        chk("t2_duty", r4, 8'h80);
        sb.push_back(8'h80);
        txn(1'b0, 7'h04, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", rd_valid, 1'b1);
            chk("t2_hold_data", rd_data, 8'h80);
            step();
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t2_cleared", rd_valid, 1'b0);
        chk("t2_data_kept", rd_data, 8'h80);
        chk("t2_idle", busy, 1'b0);
        txn(1'b1, 7'h10, 8'hFF);
        chk_regs("t3", 40'h80_00_A5_00_00);
        chk("t3_err1", err_count, 4'h1);
        rd_ready = 1'b1;
        sb.push_back(8'h00);
        txn(1'b0, 7'h7F, 8'h00);
        step();
        rd_ready = 1'b0;
        chk("t3_err2", err_count, 4'h2);
        chk("t3_rd_valid", rd_valid, 1'b0);
        txn(1'b1, 7'h00, 8'h3C);
        sb.push_back(8'h3C);
        txn(1'b0, 7'h00, 8'h00);
        step();
        txn_rw = 1'b1; txn_addr = 7'h01; txn_data = 8'h77; txn_valid = 1'b1;
        step();
        txn_valid = 1'b0;
        chk("t4_drop_err", err_count, 4'h3);
        chk("t4_drop_data", rd_data, 8'h3C);
        chk("t4_drop_valid", rd_valid, 1'b1);
        chk("t4_drop_reg", r1, 8'h00);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t4_cleared", rd_valid, 1'b0);
        for (int i = 0; i < 16; i++) txn(1'b1, 7'h20, 8'h11);
        chk("t4_saturate", err_count, 4'hF);
        chk_regs("t4", 40'h80_00_A5_00_3C);
        rst_n = 1'b0; txn_valid = 1'b1; txn_rw = 1'b1; txn_addr = 7'h00; txn_data = 8'hEE;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_txn_busy", busy, 1'b0);
        end
        chk_regs("t5", 40'h0);
        chk("t5_err", err_count, 4'h0);
        txn_valid = 1'b0;
        sb.push_back(8'h00);
        txn(1'b0, 7'h01, 8'h00);
        chk("t5_resp_pending", rd_valid, 1'b1);
        sb.delete();
        rst_n = 1'b0;
        step();
        chk("t5_reset_drops_valid", rd_valid, 1'b0);
        rst_n = 1'b1;
        txn(1'b1, 7'h03, 8'h5A);
        rd_ready = 1'b1;
        sb.push_back(8'h5A);
        txn(1'b0, 7'h03, 8'h00);
        step();
        rd_ready = 1'b0;
`ifdef REG_LOCK_EN
        txn(1'b1, 7'h05, 8'h01);
        chk("t6_lock_err", err_count, 4'h0);
        txn(1'b1, 7'h00, 8'h55);
        chk("t6_locked_reg", r0, 8'h00);
        chk("t6_locked_err", err_count, 4'h1);
        rd_ready = 1'b1;
        sb.push_back(8'h01);
        txn(1'b0, 7'h05, 8'h00);
        step();
        rd_ready = 1'b0;
        txn(1'b1, 7'h05, 8'h00);
        txn(1'b1, 7'h00, 8'h55);
        chk("t6_unlocked_reg", r0, 8'h55);
        chk("t6_unlocked_err", err_count, 4'h1);
`else
        txn(1'b1, 7'h05, 8'h01);
        chk("t6_addr5_invalid_err", err_count, 4'h1);
        txn(1'b1, 7'h00, 8'h55);
        chk("t6_write_applied", r0, 8'h55);
`endif
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
